// File: rtl/fetch_sequencer_pkg.sv
// Shared MiniAlu definitions: opcodes, instruction field layout and fetch FSM encoding.
package fetch_sequencer_pkg;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpXor  = 4'h5,
    OpShl  = 4'h6,
    OpShr  = 4'h7,
    OpMuls = 4'h8,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpBeq  = 4'hB,
    OpBne  = 4'hC,
    OpBlt  = 4'hD,
    OpLdi  = 4'hE,
    OpJmp  = 4'hF
  } opcode_e;

  // Field layout of a 28-bit instruction word.
  typedef struct packed {
    opcode_e    opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src0;
  } insn_t;

  localparam int unsigned OpcodeMsb = 27;
  localparam int unsigned OpcodeLsb = 24;
  localparam int unsigned DestMsb   = 23;
  localparam int unsigned DestLsb   = 16;

  typedef enum logic [0:0] {
    StFlush = 1'b0,
    StRun   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/issue controller: owns the PC, registers ROM words and issues them over valid/ready.
// Unconditional JMP is resolved here; execute-stage redirects flush the pending word.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSN_W   = 28,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  output logic [INSN_W-1:0] oInstruction,
  output logic              oValid,
  input  logic              iReady,
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iRedirectAddr,
  output logic [ADDR_W-1:0] oPC
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              valid_q, valid_d;
  logic              is_jmp;

  assign is_jmp = (iInstruction[OpcodeMsb:OpcodeLsb] == OpJmp);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    insn_d  = insn_q;
    valid_d = valid_q;
    if (iRedirect) begin
      // Any pending word is dropped, even if execute signalled ready this cycle.
      pc_d    = iRedirectAddr;
      valid_d = 1'b0;
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StFlush: begin
          valid_d = 1'b0;
          state_d = StRun;
        end
        StRun: begin
          if (!valid_q || iReady) begin
            if (is_jmp) begin
              pc_d    = ADDR_W'(iInstruction[DestMsb:DestLsb]);
              valid_d = 1'b0;
            end else begin
              insn_d  = iInstruction;
              opc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + 1'b1;
            end
          end
        end
        default: state_d = StFlush;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StFlush;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      insn_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
    end
  end

  assign oAddress     = pc_q;
  assign oPC          = opc_q;
  assign oInstruction = insn_q;
  assign oValid       = valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: scoreboard of handshaked words plus timing checks.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iRedirect;
  logic [15:0] iRedirectAddr;
  logic [15:0] oPC;

  logic [27:0] rom [65536];
  logic [43:0] sb_q [$];
  int          n_total = 0;
  int          n_bad   = 0;

  fetch_sequencer dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .iReady        (iReady),
    .iRedirect     (iRedirect),
    .iRedirectAddr (iRedirectAddr),
    .oPC           (oPC)
  );

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk_word(input logic [15:0] a);
    insn_t w;
    w.opcode = a[0] ? OpAdd : OpSub;
    w.dest   = a[7:0] + 8'h10;
    w.src1   = a[15:8];
    w.src0   = a[7:0];
    return w;
  endfunction

  task automatic sb_push(input logic [15:0] a);
    sb_q.push_back({a, rom[a]});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Every accepted handshake must match the next expected {pc, word}.
  always @(negedge Clock) begin
    if (!Reset && oValid && iReady && !iRedirect) begin
      check_val("sb_avail", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) check_val("sb_issue", 64'({oPC, oInstruction}), 64'(sb_q.pop_front()));
    end
  end

  initial begin
    insn_t jw;
    for (int i = 0; i < 65536; i++) rom[i] = mk_word(16'(i));

    Reset         = 1'b1;
    iReady        = 1'b0;
    iRedirect     = 1'b0;
    iRedirectAddr = '0;
    step(2);
    check_val("rst_valid", 64'(oValid), 64'd0);
    check_val("rst_addr", 64'(oAddress), 64'd0);
    check_val("rst_pc", 64'(oPC), 64'd0);
    check_val("rst_insn", 64'(oInstruction), 64'd0);

    // Straight-line issue
    for (int a = 0; a <= 4; a++) sb_push(16'(a));
    iReady = 1'b1;
    Reset  = 1'b0;
    step(1);
    check_val("first_edge1_valid", 64'(oValid), 64'd0);
    step(1);
    check_val("first_edge2_valid", 64'(oValid), 64'd1);
    check_val("first_edge2_pc", 64'(oPC), 64'd0);
    step(3);
    check_val("line_pc3", 64'(oPC), 64'd3);

    // Stall on word at PC 3
    iReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      check_val("stall_valid", 64'(oValid), 64'd1);
      check_val("stall_pc", 64'(oPC), 64'd3);
      check_val("stall_addr", 64'(oAddress), 64'd4);
      check_val("stall_insn", 64'(oInstruction), 64'(rom[3]));
    end

    // JMP at 5 back to 1
    jw.opcode = OpJmp;
    jw.dest   = 8'd1;
    jw.src1   = 8'd0;
    jw.src0   = 8'd0;
    rom[5] = jw;
    iReady = 1'b1;
    step(1);
    check_val("jmp_pre_pc", 64'(oPC), 64'd4);
    step(1);
    check_val("jmp_bubble_valid", 64'(oValid), 64'd0);
    check_val("jmp_bubble_addr", 64'(oAddress), 64'd1);
    step(1);
    check_val("jmp_tgt_valid", 64'(oValid), 64'd1);
    check_val("jmp_tgt_pc", 64'(oPC), 64'd1);
    check_val("jmp_tgt_insn", 64'(oInstruction), 64'(rom[1]));

    // Redirect during stall drops the stalled word
    iReady = 1'b0;
    step(1);
    iRedirect     = 1'b1;
    iRedirectAddr = 16'h0002;
    step(1);
    check_val("redir_valid0", 64'(oValid), 64'd0);
    check_val("redir_addr", 64'(oAddress), 64'd2);
    iRedirect = 1'b0;
    iReady    = 1'b1;
    sb_push(16'd2);
    sb_push(16'd3);
    step(1);
    check_val("redir_valid1", 64'(oValid), 64'd0);
    step(1);
    check_val("redir_tgt_pc", 64'(oPC), 64'd2);
    check_val("redir_tgt_valid", 64'(oValid), 64'd1);
    step(1);
    check_val("redir_next_pc", 64'(oPC), 64'd3);
    step(1);
    check_val("coll_jmp_on_rom", 64'(oAddress), 64'd5);

    // Redirect collides with JMP on ROM output
    iRedirect     = 1'b1;
    iRedirectAddr = 16'h0010;
    step(1);
    check_val("coll_addr", 64'(oAddress), 64'h10);
    check_val("coll_valid", 64'(oValid), 64'd0);
    iRedirect = 1'b0;
    sb_push(16'h0010);
    step(2);
    check_val("coll_tgt_pc", 64'(oPC), 64'h10);
    step(1);

    // Reset mid-stream
    Reset = 1'b1;
    step(1);
    check_val("midrst_valid", 64'(oValid), 64'd0);
    check_val("midrst_addr", 64'(oAddress), 64'd0);
    check_val("midrst_pc", 64'(oPC), 64'd0);
    check_val("midrst_insn", 64'(oInstruction), 64'd0);

    // Wrap-around
    Reset         = 1'b0;
    iRedirect     = 1'b1;
    iRedirectAddr = 16'hFFFF;
    sb_push(16'hFFFF);
    sb_push(16'h0000);
    step(1);
    check_val("wrap_addr", 64'(oAddress), 64'hFFFF);
    iRedirect = 1'b0;
    step(2);
    check_val("wrap_pc_ffff", 64'(oPC), 64'hFFFF);
    check_val("wrap_addr0", 64'(oAddress), 64'd0);
    step(1);
    check_val("wrap_pc_0", 64'(oPC), 64'd0);
    step(1);
    iReady = 1'b0;
    step(2);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
